csi_lane_aligner: RTL and testbench

//  Deskews the per-lane byte streams coming out of the per-lane byte aligners so that byte k of every lane leaves in the same cycle.

---
 rtl/csi_lane_aligner_pkg.sv | 11 +
 rtl/csi_lane_delay.sv | 33 +++
 rtl/csi_lane_aligner.sv | 97 +++++++++
 tb/tb_csi_lane_aligner.sv | 104 ++++++++++
 4 files changed

// File: rtl/csi_lane_aligner_pkg.sv
// csi_lane_aligner_pkg: shared lane widths, tap types and aligner state encoding
package csi_lane_aligner_pkg;
    localparam int NUM_LANE = 2;
    localparam int MAX_LANE_SKEW = 3;
    typedef logic [7:0] bus8_t;
    typedef logic [NUM_LANE-1:0] lane_vld_t;
    typedef bus8_t [NUM_LANE-1:0] lane_data_t;
    typedef logic [$clog2(MAX_LANE_SKEW+2)-1:0] lane_tap_t;
    typedef lane_tap_t [NUM_LANE-1:0] lane_taps_t;
    typedef enum logic [1:0] {IDLE, GATHER, LOCKED, DRAIN} align_state_t;
endpackage

// File: rtl/csi_lane_delay.sv
// csi_lane_delay: per-lane byte history with a registered, enabled tap select
module csi_lane_delay
#(
    parameter int MAX_SKEW = 3,
    parameter int TW = $clog2(MAX_SKEW+2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [TW-1:0] tap,
    input  logic [7:0]    din,
    output logic [7:0]    dout
);
    import csi_lane_aligner_pkg::*;
    bus8_t [MAX_SKEW-1:0] sr;
    bus8_t [MAX_SKEW:0] d;
    bus8_t sel;
    assign d = {sr, din};
    always_comb begin
        sel = '0;
        for (int k = 0; k <= MAX_SKEW; k++) sel = (tap == TW'(k)) ? d[k] : sel;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
            dout <= '0;
        end else begin
            sr[0] <= din;
            for (int k = 1; k < MAX_SKEW; k++) sr[k] <= sr[k-1];
            if (en) dout <= sel;
        end
    end
endmodule

// File: rtl/csi_lane_aligner.sv
// csi_lane_aligner: deskews per-lane byte streams so byte k of every lane leaves together
module csi_lane_aligner
#(
    parameter int NUM_LANE = csi_lane_aligner_pkg::NUM_LANE,
    parameter int MAX_SKEW = csi_lane_aligner_pkg::MAX_LANE_SKEW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_LANE-1:0]      lane_vld_in,
    input  logic [NUM_LANE-1:0][7:0] lane_data_in,
    input  logic                     packet_done,
    output logic                     word_vld,
    output logic [NUM_LANE-1:0][7:0] word_data,
    output logic                     locked,
    output logic                     align_err
);
    import csi_lane_aligner_pkg::*;
    localparam int TW = $clog2(MAX_SKEW+2);
    align_state_t state, state_nx;
    logic [NUM_LANE-1:0] r_vld, seen, over;
    logic [NUM_LANE-1:0][7:0] r_dat;
    logic [NUM_LANE-1:0][TW-1:0] cnt, cnt_nx, tap, tap_nx;
    logic vld_nx, err_nx, all_v, any_v;
    always_comb begin
        for (int l = 0; l < NUM_LANE; l++) begin
            seen[l] = cnt[l] != '0;
            over[l] = cnt[l] > TW'(MAX_SKEW);
        end
        all_v = &r_vld;
        any_v = |r_vld;
        state_nx = state;
        cnt_nx = cnt;
        tap_nx = tap;
        vld_nx = 1'b0;
        err_nx = 1'b0;
        case (state)
            IDLE: if (any_v) begin
                for (int l = 0; l < NUM_LANE; l++) cnt_nx[l] = TW'(r_vld[l]);
                tap_nx = '0;
                vld_nx = all_v && !packet_done;
                state_nx = !all_v ? GATHER : packet_done ? DRAIN : LOCKED;
            end
            GATHER: begin
                // a lane's count is how many older bytes it holds, i.e. its tap at lock time
                for (int l = 0; l < NUM_LANE; l++)
                    cnt_nx[l] = (r_vld[l] && !over[l]) ? cnt[l] + TW'(1) : cnt[l];
                if (packet_done) state_nx = DRAIN;
                else if (|(seen & ~r_vld) || |over) begin
                    state_nx = DRAIN;
                    err_nx = 1'b1;
                end else if (all_v) begin
                    state_nx = LOCKED;
                    tap_nx = cnt;
                    vld_nx = 1'b1;
                end
            end
            LOCKED: begin
                vld_nx = all_v && !packet_done;
                state_nx = vld_nx ? LOCKED : DRAIN;
            end
            default: if (!any_v) begin
                state_nx = IDLE;
                cnt_nx = '0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            r_vld <= '0;
            r_dat <= '0;
            cnt <= '0;
            tap <= '0;
            word_vld <= 1'b0;
            align_err <= 1'b0;
        end else begin
            state <= state_nx;
            r_vld <= lane_vld_in;
            r_dat <= lane_data_in;
            cnt <= cnt_nx;
            tap <= tap_nx;
            word_vld <= vld_nx;
            align_err <= err_nx;
        end
    end
    assign locked = state == LOCKED;
    for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
        csi_lane_delay #(.MAX_SKEW(MAX_SKEW), .TW(TW)) u_dly (
            .clk(clk),
            .reset(reset),
            .en(vld_nx),
            .tap(tap_nx[l]),
            .din(r_dat[l]),
            .dout(word_data[l])
        );
    end
endmodule

// File: tb/tb_csi_lane_aligner.sv
// tb_csi_lane_aligner: directed skew/drop/packet_done/reset scenarios for a 2-lane aligner
module tb_csi_lane_aligner;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic packet_done = 1'b0;
    logic [1:0] lane_vld_in = '0;
    logic [1:0][7:0] lane_data_in = '0;
    logic word_vld, locked, align_err;
    logic [1:0][7:0] word_data;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    csi_lane_aligner #(.NUM_LANE(2), .MAX_SKEW(3)) dut (
        .clk(clk),
        .reset(reset),
        .lane_vld_in(lane_vld_in),
        .lane_data_in(lane_data_in),
        .packet_done(packet_done),
        .word_vld(word_vld),
        .word_data(word_data),
        .locked(locked),
        .align_err(align_err)
    );

    // byte k of lane l: sync byte first, then 11/22, 33/44, ...
    function automatic logic [7:0] bval(int l, int k);
        return (k == 0) ? 8'hB8 : 8'(17 * (2 * k - 1 + l));
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // lane l valid on input cycles s_l .. s_l+len_l-1; pd_at/rst_at = -1 for none
    task automatic run(string tag, int s0, int s1, int len0, int len1, int pd_at, int rst_at, bit exp_err);
        int t_last = (s0 > s1) ? s0 : s1;
        int end_o = ((s0 + len0 < s1 + len1) ? s0 + len0 : s1 + len1) + 2;
        int pulses = 0;
        logic prev = 1'b0;
        if (pd_at >= 0 && pd_at + 1 < end_o) end_o = pd_at + 1;
        if (rst_at >= 0 && rst_at + 1 < end_o) end_o = rst_at + 1;
        for (int c = 0; c < 30; c++) begin
            int o;
            int k;
            logic exp_v;
            lane_vld_in[0] = (c >= s0) && (c < s0 + len0);
            lane_vld_in[1] = (c >= s1) && (c < s1 + len1);
            lane_data_in[0] = lane_vld_in[0] ? bval(0, c - s0) : 8'hEE;
            lane_data_in[1] = lane_vld_in[1] ? bval(1, c - s1) : 8'hEE;
            packet_done = (c == pd_at);
            reset = (c == rst_at);
            @(posedge clk);
            #1;
            o = c + 1;
            k = o - t_last - 2;
            exp_v = !exp_err && (o >= t_last + 2) && (o < end_o);
            chk($sformatf("%s word_vld o=%0d", tag, o), 32'(word_vld), 32'(exp_v));
            chk($sformatf("%s locked o=%0d", tag, o), 32'(locked), 32'(exp_v));
            if (exp_v)
                chk($sformatf("%s word_data k=%0d", tag, k), 32'(word_data), 32'({bval(1, k), bval(0, k)}));
            if (o == rst_at + 1)
                chk($sformatf("%s word_data after reset", tag), 32'(word_data), 32'h0);
            if (exp_err) begin
                chk($sformatf("%s align_err width o=%0d", tag, o), 32'(prev & align_err), 32'h0);
                pulses += int'(align_err);
                prev = align_err;
            end else
                chk($sformatf("%s align_err o=%0d", tag, o), 32'(align_err), 32'h0);
        end
        if (exp_err) chk($sformatf("%s align_err pulses", tag), 32'(pulses), 32'd1);
        lane_vld_in = '0;
        lane_data_in = '0;
        packet_done = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset word_vld", 32'(word_vld), 32'h0);
        chk("reset word_data", 32'(word_data), 32'h0);
        chk("reset locked", 32'(locked), 32'h0);
        chk("reset align_err", 32'(align_err), 32'h0);
        reset = 1'b0;
        run("zero_skew", 0, 0, 4, 4, -1, -1, 1'b0);
        run("lane1_late1", 0, 1, 4, 4, -1, -1, 1'b0);
        run("lane0_late2", 2, 0, 6, 6, -1, -1, 1'b0);
        run("skew3", 0, 3, 6, 6, -1, -1, 1'b0);
        run("skew4", 0, 4, 6, 6, -1, -1, 1'b1);
        run("relock", 0, 0, 3, 3, -1, -1, 1'b0);
        run("pkt_done", 0, 0, 8, 8, 3, -1, 1'b0);
        run("pd_at_lock", 0, 1, 5, 5, 2, -1, 1'b0);
        run("reset_mid", 0, 0, 4, 4, -1, 3, 1'b0);
        run("after_reset", 0, 1, 3, 5, -1, -1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
